// File: rtl/spi_slave_regfile.sv
// SPI mode-3 slave register file: {RW,MS,addr[5:0]} command byte, then data bytes with optional auto-increment.
// Optional 3-wire read path enabled by defining SPI_SLAVE_3WIRE_EN (SIM = bit0 of the CTRL4 register).
module spi_slave_regfile #(
  parameter int unsigned NREGS       = 64,
  parameter logic [5:0]  WHOAMI_ADDR = 6'h0F,
  parameter logic [7:0]  WHOAMI_VAL  = 8'h33,
  parameter logic [5:0]  CTRL4_ADDR  = 6'h23,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       csn,
  input  logic       sck,
  input  logic       mosi,
  output logic       miso,
  output logic       miso_oe,
  output logic       sdio_out,
  output logic       sdio_oe,
  input  logic       loc_we,
  input  logic [5:0] loc_addr,
  input  logic [7:0] loc_wdata,
  output logic       wr_strobe,
  output logic [5:0] wr_addr,
  output logic [7:0] wr_data
);

  typedef enum logic [1:0] {IDLE, CMD, DATA} state_t;

  state_t state, state_nx;

  logic [SYNC_STAGES-1:0] csn_sync, sck_sync, mosi_sync;
  logic       csn_d, sck_d;
  logic       csn_s, sck_s, mosi_s;
  logic       csn_fall_c, csn_rise_c, sck_fall_c, sck_rise_c;

  logic [2:0] bit_cnt;
  logic [7:0] rx_sh;
  logic [7:0] tx_sh;
  logic       rw, ms;
  logic [5:0] addr;
  logic       sim;

  logic [7:0] regs [NREGS];

  logic       shift_in_c, cmd_done_c, commit_c, adv_c, load_c, shift_out_c;
  logic [7:0] rx_byte_c, rd_byte_c;
  logic       addr_ok_c, loc_ok_c, tx_bit_c;
  logic [5:0] addr_next_c;

  // csn chain resets low so a csn already held low at reset release cannot fake a frame start
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      csn_sync  <= '0;
      sck_sync  <= '1;
      mosi_sync <= '0;
      csn_d     <= 1'b0;
      sck_d     <= 1'b1;
    end else begin
      csn_sync  <= {csn_sync[SYNC_STAGES-2:0], csn};
      sck_sync  <= {sck_sync[SYNC_STAGES-2:0], sck};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
      csn_d     <= csn_s;
      sck_d     <= sck_s;
    end
  end

  assign csn_s      = csn_sync[SYNC_STAGES-1];
  assign sck_s      = sck_sync[SYNC_STAGES-1];
  assign mosi_s     = mosi_sync[SYNC_STAGES-1];
  assign csn_fall_c = csn_d & ~csn_s;
  assign csn_rise_c = ~csn_d & csn_s;
  assign sck_fall_c = sck_d & ~sck_s;
  assign sck_rise_c = ~sck_d & sck_s;

  assign rx_byte_c   = {rx_sh[6:0], mosi_s};
  assign addr_ok_c   = {1'b0, addr} < 7'(NREGS);
  assign loc_ok_c    = {1'b0, loc_addr} < 7'(NREGS);
  assign addr_next_c = (addr == 6'(NREGS - 1)) ? 6'd0 : addr + 6'd1;
  assign tx_bit_c    = load_c ? rd_byte_c[7] : tx_sh[7];

  always_comb begin
    rd_byte_c = 8'h00;
    if (addr_ok_c) rd_byte_c = (addr == WHOAMI_ADDR) ? WHOAMI_VAL : regs[addr];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (csn_fall_c) state_nx = CMD;
      CMD:     if (csn_rise_c) state_nx = IDLE;
               else if (shift_in_c && bit_cnt == 3'd7) state_nx = DATA;
      DATA:    if (csn_rise_c) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Per-clock action decodes; a csn rise overrides any coincident sck edge
  always_comb begin
    shift_in_c  = 1'b0;
    cmd_done_c  = 1'b0;
    commit_c    = 1'b0;
    adv_c       = 1'b0;
    load_c      = 1'b0;
    shift_out_c = 1'b0;
    if (state != IDLE && !csn_rise_c) begin
      shift_in_c = sck_rise_c;
      if (state == CMD) begin
        cmd_done_c = sck_rise_c && bit_cnt == 3'd7;
      end else if (state == DATA) begin
        commit_c    = sck_rise_c && bit_cnt == 3'd7 && !rw && addr_ok_c && addr != WHOAMI_ADDR;
        adv_c       = sck_rise_c && bit_cnt == 3'd7 && ms;
        load_c      = sck_fall_c && rw && bit_cnt == 3'd0;
        shift_out_c = sck_fall_c && rw && bit_cnt != 3'd0;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bit_cnt   <= 3'd0;
      rx_sh     <= 8'h00;
      tx_sh     <= 8'h00;
      rw        <= 1'b0;
      ms        <= 1'b0;
      addr      <= 6'd0;
      miso      <= 1'b0;
      miso_oe   <= 1'b0;
      wr_strobe <= 1'b0;
      wr_addr   <= 6'd0;
      wr_data   <= 8'h00;
    end else begin
      wr_strobe <= commit_c;
      if (commit_c) begin
        wr_addr <= addr;
        wr_data <= rx_byte_c;
      end
      if (csn_fall_c) bit_cnt <= 3'd0;
      if (shift_in_c) begin
        rx_sh   <= rx_byte_c;
        bit_cnt <= bit_cnt + 3'd1;
      end
      if (cmd_done_c) begin
        rw   <= rx_byte_c[7];
        ms   <= rx_byte_c[6];
        addr <= rx_byte_c[5:0];
      end else if (adv_c) begin
        addr <= addr_next_c;
      end
      if (load_c)           tx_sh <= {rd_byte_c[6:0], 1'b0};
      else if (shift_out_c) tx_sh <= {tx_sh[6:0], 1'b0};
      if (csn_rise_c) begin
        miso    <= 1'b0;
        miso_oe <= 1'b0;
      end else if (load_c || shift_out_c) begin
        miso <= tx_bit_c & ~sim;
        if (load_c) miso_oe <= ~sim;
      end
    end
  end

  // SPI commit wins over a local write to the same address in the same cycle
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= 8'h00;
    end else begin
      if (loc_we && loc_ok_c && !(commit_c && loc_addr == addr)) regs[loc_addr] <= loc_wdata;
      if (commit_c) regs[addr] <= rx_byte_c;
    end
  end

`ifdef SPI_SLAVE_3WIRE_EN
  localparam bit             CTRL4_OK  = {1'b0, CTRL4_ADDR} < 7'(NREGS);
  localparam logic [5:0]     CTRL4_IDX = CTRL4_OK ? CTRL4_ADDR : 6'd0;

  // SIM is sampled at frame start so a change applies from the next frame
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sim      <= 1'b0;
      sdio_out <= 1'b0;
      sdio_oe  <= 1'b0;
    end else begin
      if (csn_fall_c) sim <= CTRL4_OK & regs[CTRL4_IDX][0];
      if (csn_rise_c) begin
        sdio_out <= 1'b0;
        sdio_oe  <= 1'b0;
      end else if (load_c || shift_out_c) begin
        sdio_out <= tx_bit_c & sim;
        if (load_c) sdio_oe <= sim;
      end
    end
  end
`else
  logic unused_ctrl4;
  assign unused_ctrl4 = ^CTRL4_ADDR;
  assign sim          = 1'b0;
  assign sdio_out     = 1'b0;
  assign sdio_oe      = 1'b0;
`endif

endmodule

// File: tb/tb_spi_slave_regfile.sv
// Directed bench for spi_slave_regfile (NREGS=48): a mode-3 SPI master task with hand-computed expectations.
// The final 3-wire step follows SPI_SLAVE_3WIRE_EN when it is defined for the build.
module tb_spi_slave_regfile;

  logic       clk = 1'b0;
  logic       reset, csn, sck, mosi, loc_we;
  logic [5:0] loc_addr;
  logic [7:0] loc_wdata;
  logic       miso, miso_oe, sdio_out, sdio_oe, wr_strobe;
  logic [5:0] wr_addr;
  logic [7:0] wr_data;

  int vectors = 0;
  int miscompares = 0;
  int wr_cnt = 0;
  int w0;
  bit sim_exp = 1'b0;
  logic [63:0] rx_m, rx_s, oe_m, oe_s;

  spi_slave_regfile #(.NREGS(48)) dut (
    .clk(clk), .reset(reset), .csn(csn), .sck(sck), .mosi(mosi),
    .miso(miso), .miso_oe(miso_oe), .sdio_out(sdio_out), .sdio_oe(sdio_oe),
    .loc_we(loc_we), .loc_addr(loc_addr), .loc_wdata(loc_wdata),
    .wr_strobe(wr_strobe), .wr_addr(wr_addr), .wr_data(wr_data)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (wr_strobe === 1'b1) wr_cnt <= wr_cnt + 1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Mode-3 master: change data on falling sck, capture miso/sdio on rising sck
  task automatic xfer(input int nbits, input logic [63:0] tx);
    rx_m = '0; rx_s = '0; oe_m = '0; oe_s = '0;
    @(negedge clk);
    csn = 1'b0;
    clks(8);
    for (int i = nbits - 1; i >= 0; i--) begin
      sck  = 1'b0;
      mosi = tx[i];
      clks(8);
      sck  = 1'b1;
      rx_m = {rx_m[62:0], miso};
      rx_s = {rx_s[62:0], sdio_out};
      oe_m = {oe_m[62:0], miso_oe};
      oe_s = {oe_s[62:0], sdio_oe};
      clks(8);
    end
    csn  = 1'b1;
    mosi = 1'b0;
    clks(16);
  endtask

  task automatic loc_write(input logic [5:0] a, input logic [7:0] d);
    @(negedge clk);
    loc_we = 1'b1; loc_addr = a; loc_wdata = d;
    @(negedge clk);
    loc_we = 1'b0;
  endtask

  task automatic read16(input string tag, input logic [7:0] cmd, input logic [7:0] exp);
    xfer(16, {48'h0, cmd, 8'h00});
    if (sim_exp) begin
      check(tag, 64'(rx_s[7:0]), 64'(exp));
      check({tag, "_sdio_oe"}, 64'(oe_s[15:0]), 64'h00FF);
      check({tag, "_miso_oe"}, 64'(oe_m[15:0]), 64'h0000);
    end else begin
      check(tag, 64'(rx_m[7:0]), 64'(exp));
      check({tag, "_miso_oe"}, 64'(oe_m[15:0]), 64'h00FF);
      check({tag, "_sdio_oe"}, 64'(oe_s[15:0]), 64'h0000);
    end
    check({tag, "_idle"}, 64'({miso, miso_oe, sdio_out, sdio_oe}), 64'h0);
  endtask

  initial begin
    reset = 1'b1; csn = 1'b1; sck = 1'b1; mosi = 1'b0;
    loc_we = 1'b0; loc_addr = 6'd0; loc_wdata = 8'h00;
    clks(3);
    reset = 1'b0;
    clks(8);
    check("rst_outs", 64'({miso, miso_oe, sdio_out, sdio_oe, wr_strobe}), 64'h0);
    check("rst_wr_addr", 64'(wr_addr), 64'h0);
    check("rst_wr_data", 64'(wr_data), 64'h0);

    read16("whoami", 8'h8F, 8'h33);

    // write CTRL4=1 then read it back (3-wire build switches to SDIO from the next frame)
    w0 = wr_cnt;
    xfer(16, 64'h2301);
    check("wr23_cnt", 64'(wr_cnt - w0), 64'd1);
    check("wr23_addr", 64'(wr_addr), 64'h23);
    check("wr23_data", 64'(wr_data), 64'h01);
`ifdef SPI_SLAVE_3WIRE_EN
    sim_exp = 1'b1;
`endif
    read16("rb23", 8'hA3, 8'h01);
    xfer(16, 64'h2300);
    sim_exp = 1'b0;
    check("wr23_clr_data", 64'(wr_data), 64'h00);
    read16("rb23_clr", 8'hA3, 8'h00);

    // auto-increment read burst
    for (int i = 0; i < 6; i++) loc_write(6'(6'h28 + i), 8'(8'h10 + i));
    xfer(56, {8'h00, 8'hE8, 48'h0});
    check("burst_data", 64'(rx_m[47:0]), 64'h1011_1213_1415);
    check("burst_oe", 64'(oe_m[55:0]), 64'h00_FFFF_FFFF_FFFF);

    // burst wraps NREGS-1 -> 0
    loc_write(6'h2F, 8'hA5);
    loc_write(6'h00, 8'h5A);
    xfer(24, {40'h0, 8'hEF, 16'h0});
    check("wrap_data", 64'(rx_m[15:0]), 64'hA55A);

    // MS=0 repeats the same register
    xfer(24, {40'h0, 8'hA8, 16'h0});
    check("fixed_data", 64'(rx_m[15:0]), 64'h1010);

    // auto-increment write burst
    w0 = wr_cnt;
    xfer(24, {40'h0, 8'h68, 8'hC1, 8'hC2});
    check("bw_cnt", 64'(wr_cnt - w0), 64'd2);
    check("bw_addr", 64'(wr_addr), 64'h29);
    check("bw_data", 64'(wr_data), 64'hC2);
    read16("bw_rb28", 8'hA8, 8'hC1);
    read16("bw_rb29", 8'hA9, 8'hC2);

    // abort after 5 data bits
    w0 = wr_cnt;
    xfer(13, {51'h0, 8'h20, 5'b10110});
    check("abort_cnt", 64'(wr_cnt - w0), 64'd0);
    read16("abort_rb20", 8'hA0, 8'h00);
    read16("abort_whoami", 8'h8F, 8'h33);

    // out-of-range and read-only addresses
    w0 = wr_cnt;
    xfer(16, 64'h3255);
    check("oor_cnt", 64'(wr_cnt - w0), 64'd0);
    read16("oor_rb32", 8'hB2, 8'h00);
    w0 = wr_cnt;
    xfer(16, 64'h0F77);
    check("ro_cnt", 64'(wr_cnt - w0), 64'd0);
    read16("ro_whoami", 8'h8F, 8'h33);
    loc_write(6'h30, 8'hFF);
    read16("oor_loc", 8'hB0, 8'h00);

    // SIM=1: WHOAMI read appears on SDIO only in the 3-wire build
    xfer(16, 64'h2301);
`ifdef SPI_SLAVE_3WIRE_EN
    sim_exp = 1'b1;
`endif
    read16("sim_whoami", 8'h8F, 8'h33);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
